// File: rtl/instr_mem_resp.sv
// Multi-cycle instruction memory: 16-bit words, byte address in, Rd/Wr request
// accepted when idle or completing, answered by a one-cycle Done after LATENCY edges.
module instr_mem_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err,
    output logic [1:0]  fsm_state
);

    // Handshake: a request is taken on any rising edge where Rd|Wr is high and the
    // FSM is IDLE or DONE; Done/err pulse for exactly one cycle, Stall marks BUSY.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    state_t                  state;
    logic [3:0]              count;
    logic [15:0]             result_q;
    logic                    err_q;
    logic [15:0]             mem [0:(1 << DEPTH_LOG2) - 1];

    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    accept;
    logic                    req_err;
    logic                    mem_we;
    logic [15:0]             req_data;
    logic                    unused_addr;

    assign word_idx    = Addr[DEPTH_LOG2:1];
    assign unused_addr = ^(Addr >> (DEPTH_LOG2 + 1));
    assign accept      = ((state == IDLE) || (state == DONE)) && (Rd || Wr);
    assign req_err     = Addr[0] | (Rd & Wr);
    assign mem_we      = accept && Wr && !req_err && !rst;
    // The array is sampled at the accepting edge; only the result is carried forward.
    assign req_data    = (Rd && !req_err) ? mem[word_idx] : 16'h0000;
    assign Stall       = (state == BUSY);
    assign fsm_state   = state;

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= DataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            result_q <= 16'h0000;
            err_q    <= 1'b0;
            DataOut  <= 16'h0000;
            Done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            Done    <= 1'b0;
            err     <= 1'b0;
            DataOut <= 16'h0000;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        count    <= COUNT_LOAD;
                        result_q <= req_data;
                        err_q    <= req_err;
                        if (LATENCY == 1) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            DataOut <= req_data;
                            err     <= req_err;
                        end else begin
                            state <= BUSY;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state   <= DONE;
                        Done    <= 1'b1;
                        DataOut <= result_q;
                        err     <= err_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_mem_resp.md
Name: instr_mem_resp

Overview:
Multi-cycle instruction-memory responder that serves the fetch stage's read requests through a Rd/Stall/Done handshake.
It replaces the fixed single-cycle instruction memory so fetch can be verified against realistic memory latency.
A write port preloads program images from the bench or loader.
Word-addressed storage of 16-bit instructions; byte address in, halfword out.

Parameters:
DEPTH_LOG2, 10, log2 of number of 16-bit words stored (1024 words = 2 KB)
LATENCY, 4, clock edges from request acceptance to Done; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
Rd  input  1  read request, sampled only when idle
Wr  input  1  write (preload) request, sampled only when idle
Addr  input  16  byte address; bit 0 must be 0
DataIn  input  16  write data
DataOut  output  16  read data, valid only while Done=1
Done  output  1  one-cycle completion pulse
Stall  output  1  high while a request is in flight and not yet done; new requests are ignored
err  output  1  one-cycle error pulse, coincident with Done

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - DataOut=16'h0000, Done=0, Stall=0, err=0.
  - FSM returns to IDLE and the latency counter clears.
  - Storage array is NOT cleared by reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Rd|Wr high at a clock edge means the request is accepted.
  - That edge latches Addr, DataIn, Rd, Wr.
  - Counter loads LATENCY-1.
  - Next state is DONE if LATENCY=1, else BUSY.
  - Nothing is accepted if Rd=Wr=0.
- BUSY:
  - Stall=1.
  - Counter decrements each edge; goes to DONE when the counter reaches 1 at an edge.
  - Rd/Wr/Addr changes are ignored.
- DONE:
  - Done=1 and Stall=0 for exactly one cycle.
  - DataOut holds the read data; for writes, DataOut=16'h0000.
  - A new request presented in DONE is accepted at the same edge that leaves DONE, giving back-to-back throughput of one request per LATENCY cycles.
  - With no new request, the next state is IDLE.
- Latency: Done is asserted in the cycle that begins exactly LATENCY edges after the accepting edge. For LATENCY=1, Stall is never asserted.
- Array access:
  - Word index = Addr[DEPTH_LOG2:1]; Addr bits above DEPTH_LOG2 are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+1) bytes.
  - A write commits to the array at the accepting edge.
  - A read samples the array at the accepting edge, so a read accepted immediately after a write's DONE sees the new data.
- Errors (err=1 with Done, no array access, DataOut=16'h0000):
  - Addr[0]=1.
  - Rd and Wr both high at acceptance.
- Reset mid-operation:
  - An in-flight request is abandoned; no Done or err is produced.
  - A write already committed at its accepting edge stays committed.
- Outside DONE, DataOut=16'h0000 and err=0.
- Done and err are registered outputs. Stall is decoded from state (BUSY) and is combinational from flops only, never from inputs.

Test Plan:
1. Reset, then Wr=1, Addr=16'h0010, DataIn=16'hA5C3 for one cycle; then Rd=1, Addr=16'h0010 (LATENCY=4) -> Stall=1 for 3 cycles, Done=1 in the 4th cycle after acceptance, DataOut=16'hA5C3, err=0.
2. Back-to-back reads: hold Rd=1 and present Addr 16'h0000 then 16'h0002 (preloaded 16'h1111, 16'h2222) -> Done pulses 4 cycles apart with DataOut 16'h1111 then 16'h2222; Stall is low only in the Done cycles.
3. Rd=1, Addr=16'h0013 (odd) -> after 4 cycles Done=1, err=1, DataOut=16'h0000; word 9 is unchanged on a subsequent read.
4. Rd=1 and Wr=1 together with Addr=16'h0020 -> Done=1, err=1, array unchanged; in BUSY, toggling Rd and Addr has no effect on the result.
5. Wrap: DEPTH_LOG2=10, write 16'hBEEF to Addr=16'h0804; read Addr=16'h0004 -> DataOut=16'hBEEF.
6. Assert rst for one cycle during BUSY of a read -> no Done/err pulse, Stall=0 the next cycle; a new read is accepted immediately after, and a previously written word still reads back intact. Repeat scenario 1 with LATENCY=1 -> Done the cycle after acceptance, Stall never high.
